// File: rtl/usb_sched_pkg.sv
// Shared types and constants for the interrupt-IN poll scheduler.
package usb_sched_pkg;

    // Width of the consecutive-error counter
    localparam int ERR_CNT_W = 4;

    // Result code reported by the transaction engine together with xfer_done_i
    typedef enum logic [1:0] {
        DATA_ACK = 2'd0,
        NAK      = 2'd1,
        STALL    = 2'd2,
        ERR      = 2'd3
    } xfer_result_e;

    // Scheduler states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_REQ        = 3'd2,
        ST_BUSY       = 3'd3,
        ST_HALT       = 3'd4
    } sched_state_e;

endpackage

// File: rtl/usb_frame_timer.sv
// Free-running 1 ms frame timer; sof_o marks the last cycle of each frame.
module usb_frame_timer #(
    parameter int CLK_PER_MS = 60000
) (
    input  logic clk,
    input  logic rst,
    output logic sof_o
);

    localparam int CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_MS - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..CLK_PER_MS-1 and wrap, independent of scheduler state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sof_o = (cnt == LAST);

endmodule

// File: rtl/usb_poll_scheduler.sv
// Periodic interrupt-IN poll scheduler: frame pacing, request handshake,
// result interpretation, DATA0/DATA1 toggle tracking, retry and halt policy.
module usb_poll_scheduler
    import usb_sched_pkg::*;
#(
    parameter int CLK_PER_MS  = 60000,
    parameter int MAX_ERR     = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_connect_i,
    input  logic                 enable_i,
    input  logic                 clear_halt_i,
    input  logic [6:0]           dev_addr_i,
    input  logic [3:0]           ep_i,
    input  logic [7:0]           interval_i,
    output logic                 xfer_req_o,
    input  logic                 xfer_ack_i,
    output logic [6:0]           xfer_addr_o,
    output logic [3:0]           xfer_ep_o,
    input  logic                 xfer_done_i,
    input  logic [1:0]           xfer_result_i,
    input  logic                 rx_toggle_i,
    output logic                 sof_o,
    output logic                 report_valid_o,
    output logic                 halted_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0]      WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_LIM  = ERR_CNT_W'(MAX_ERR);
    localparam logic [ERR_CNT_W-1:0] ERR_TOP  = '1;

    // Error counter increment that sticks at all-ones instead of wrapping
    function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] e);
        return (e == ERR_TOP) ? e : e + 1'b1;
    endfunction

    sched_state_e           state, next_state;
    xfer_result_e           result;
    logic [7:0]             fcnt;
    logic [7:0]             interval_load;
    logic                   exp_toggle;
    logic                   rv_q;
    logic [WD_W-1:0]        wd;
    logic                   done_evt;
    logic                   timeout_evt;
    logic [ERR_CNT_W-1:0]   err_next;
    logic                   err_halt;

    usb_frame_timer #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_frame_timer (
        .clk   (clk),
        .rst   (rst),
        .sof_o (sof_o)
    );

    assign result        = xfer_result_e'(xfer_result_i);
    assign interval_load = (interval_i == 8'd0) ? 8'd1 : interval_i;
    assign done_evt      = (state == ST_BUSY) && xfer_done_i;
    assign timeout_evt   = (state == ST_BUSY) && !xfer_done_i && (wd == WD_LAST);
    assign err_next      = err_sat_inc(err_count_o);
    assign err_halt      = (err_next >= ERR_LIM);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; disconnect overrides every other event
    always_comb begin
        next_state = state;
        if (!host_connect_i) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable_i) next_state = ST_WAIT_FRAME;
                end
                ST_WAIT_FRAME: begin
                    if (!enable_i)                   next_state = ST_IDLE;
                    else if (sof_o && fcnt <= 8'd1)  next_state = ST_REQ;
                end
                ST_REQ: begin
                    if (xfer_ack_i) next_state = ST_BUSY;
                end
                ST_BUSY: begin
                    if (done_evt) begin
                        case (result)
                            STALL:   next_state = ST_HALT;
                            ERR:     next_state = err_halt ? ST_HALT :
                                                  (enable_i ? ST_WAIT_FRAME : ST_IDLE);
                            default: next_state = enable_i ? ST_WAIT_FRAME : ST_IDLE;
                        endcase
                    end else if (timeout_evt) begin
                        next_state = err_halt ? ST_HALT :
                                     (enable_i ? ST_WAIT_FRAME : ST_IDLE);
                    end
                end
                ST_HALT: begin
                    if (clear_halt_i) next_state = ST_WAIT_FRAME;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Outputs; request and report are gated off combinationally on disconnect
    always_comb begin
        xfer_req_o     = (state == ST_REQ) && host_connect_i;
        report_valid_o = rv_q && host_connect_i;
        halted_o       = (state == ST_HALT);
    end

    // Scheduler bookkeeping: frame countdown, toggle, errors, watchdog, target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt        <= 8'd1;
            exp_toggle  <= 1'b0;
            err_count_o <= '0;
            rv_q        <= 1'b0;
            wd          <= '0;
            xfer_addr_o <= '0;
            xfer_ep_o   <= '0;
        end else if (!host_connect_i) begin
            exp_toggle <= 1'b0;
            rv_q       <= 1'b0;
            wd         <= '0;
        end else begin
            rv_q <= 1'b0;

            // Target is latched only when entering REQ so it is stable for the engine
            if (next_state == ST_REQ && state != ST_REQ) begin
                xfer_addr_o <= dev_addr_i;
                xfer_ep_o   <= ep_i;
            end

            case (state)
                ST_IDLE: begin
                    if (enable_i) begin
                        fcnt        <= 8'd1;
                        exp_toggle  <= 1'b0;
                        err_count_o <= '0;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (enable_i && sof_o && fcnt > 8'd1) begin
                        fcnt <= fcnt - 8'd1;
                    end
                end
                ST_REQ: begin
                    wd <= '0;
                end
                ST_BUSY: begin
                    wd <= wd + 1'b1;
                    if (done_evt) begin
                        case (result)
                            DATA_ACK: begin
                                err_count_o <= '0;
                                fcnt        <= interval_load;
                                // A repeated toggle is a retransmitted duplicate: drop it
                                if (rx_toggle_i == exp_toggle) begin
                                    exp_toggle <= ~exp_toggle;
                                    rv_q       <= 1'b1;
                                end
                            end
                            NAK: begin
                                fcnt <= 8'd1;
                            end
                            ERR: begin
                                err_count_o <= err_next;
                                fcnt        <= 8'd1;
                            end
                            default: ;
                        endcase
                    end else if (timeout_evt) begin
                        err_count_o <= err_next;
                        fcnt        <= 8'd1;
                    end
                end
                ST_HALT: begin
                    if (clear_halt_i) begin
                        err_count_o <= '0;
                        exp_toggle  <= 1'b0;
                        fcnt        <= 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_poll_scheduler.sv
// Directed bench for usb_poll_scheduler acting as the transaction engine.
module tb_usb_poll_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       host_connect_i;
    logic       enable_i;
    logic       clear_halt_i;
    logic [6:0] dev_addr_i;
    logic [3:0] ep_i;
    logic [7:0] interval_i;
    logic       xfer_req_o;
    logic       xfer_ack_i;
    logic [6:0] xfer_addr_o;
    logic [3:0] xfer_ep_o;
    logic       xfer_done_i;
    logic [1:0] xfer_result_i;
    logic       rx_toggle_i;
    logic       sof_o;
    logic       report_valid_o;
    logic       halted_o;
    logic [3:0] err_count_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] R_ACK   = 2'd0;
    localparam logic [1:0] R_NAK   = 2'd1;
    localparam logic [1:0] R_ERR   = 2'd3;

    usb_poll_scheduler #(
        .CLK_PER_MS  (100),
        .MAX_ERR     (3),
        .TIMEOUT_CYC (1024)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .host_connect_i (host_connect_i),
        .enable_i       (enable_i),
        .clear_halt_i   (clear_halt_i),
        .dev_addr_i     (dev_addr_i),
        .ep_i           (ep_i),
        .interval_i     (interval_i),
        .xfer_req_o     (xfer_req_o),
        .xfer_ack_i     (xfer_ack_i),
        .xfer_addr_o    (xfer_addr_o),
        .xfer_ep_o      (xfer_ep_o),
        .xfer_done_i    (xfer_done_i),
        .xfer_result_i  (xfer_result_i),
        .rx_toggle_i    (rx_toggle_i),
        .sof_o          (sof_o),
        .report_valid_o (report_valid_o),
        .halted_o       (halted_o),
        .err_count_o    (err_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance to just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until sof_o is seen high, bounded to a bit more than one frame
    task automatic wait_sof(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!sof_o && n < 150);
        chk({tag, "_sof_seen"}, {31'd0, sof_o}, 32'd1);
    endtask

    // Next frame must raise a request exactly one cycle after sof_o
    task automatic poll_after_sof(input string tag, input logic [6:0] ea, input logic [3:0] ee);
        wait_sof(tag);
        chk({tag, "_req_at_sof"}, {31'd0, xfer_req_o}, 32'd0);
        step();
        chk({tag, "_req_rise"}, {31'd0, xfer_req_o}, 32'd1);
        chk({tag, "_addr"}, {25'd0, xfer_addr_o}, {25'd0, ea});
        chk({tag, "_ep"}, {28'd0, xfer_ep_o}, {28'd0, ee});
    endtask

    task automatic do_ack(input string tag);
        xfer_ack_i = 1'b1;
        step();
        xfer_ack_i = 1'b0;
        chk({tag, "_req_drop"}, {31'd0, xfer_req_o}, 32'd0);
    endtask

    task automatic do_done(input string tag, input logic [1:0] res, input logic tog,
                           input logic exp_rv, input logic [3:0] exp_err);
        step();
        step();
        xfer_done_i   = 1'b1;
        xfer_result_i = res;
        rx_toggle_i   = tog;
        step();
        xfer_done_i   = 1'b0;
        chk({tag, "_rv"}, {31'd0, report_valid_o}, {31'd0, exp_rv});
        chk({tag, "_err"}, {28'd0, err_count_o}, {28'd0, exp_err});
        step();
        chk({tag, "_rv_end"}, {31'd0, report_valid_o}, 32'd0);
    endtask

    // Pass through IDLE to restart with expected toggle 0 and fcnt 1
    task automatic restart_enable();
        enable_i = 1'b0;
        step();
        enable_i = 1'b1;
        step();
    endtask

    initial begin
        rst            = 1'b1;
        host_connect_i = 1'b1;
        enable_i       = 1'b1;
        clear_halt_i   = 1'b0;
        dev_addr_i     = 7'h2A;
        ep_i           = 4'h3;
        interval_i     = 8'd3;
        xfer_ack_i     = 1'b0;
        xfer_done_i    = 1'b0;
        xfer_result_i  = 2'd0;
        rx_toggle_i    = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_req",    {31'd0, xfer_req_o}, 32'd0);
        chk("rst_sof",    {31'd0, sof_o}, 32'd0);
        chk("rst_rv",     {31'd0, report_valid_o}, 32'd0);
        chk("rst_halted", {31'd0, halted_o}, 32'd0);
        chk("rst_err",    {28'd0, err_count_o}, 32'd0);
        chk("rst_addr",   {25'd0, xfer_addr_o}, 32'd0);
        chk("rst_ep",     {28'd0, xfer_ep_o}, 32'd0);
        rst = 1'b0;
        step();

        // Interval 3, accepted data toggles 0,1,0: one poll every third frame
        for (int p = 0; p < 3; p++) begin
            if (p != 0) begin
                wait_sof("t1_skip_a");
                step();
                chk("t1_skip_a_req", {31'd0, xfer_req_o}, 32'd0);
                wait_sof("t1_skip_b");
                step();
                chk("t1_skip_b_req", {31'd0, xfer_req_o}, 32'd0);
            end
            poll_after_sof("t1_poll", 7'h2A, 4'h3);
            do_ack("t1");
            do_done("t1", R_ACK, p[0], 1'b1, 4'd0);
        end

        // NAK, NAK, DATA_ACK on three consecutive frames
        interval_i = 8'd1;
        dev_addr_i = 7'h15;
        ep_i       = 4'h5;
        restart_enable();
        poll_after_sof("t2_f1", 7'h15, 4'h5);
        do_ack("t2_f1");
        do_done("t2_nak1", R_NAK, 1'b0, 1'b0, 4'd0);
        // A stray done outside BUSY must not produce a report or flip the toggle
        xfer_done_i   = 1'b1;
        xfer_result_i = R_ACK;
        rx_toggle_i   = 1'b0;
        step();
        xfer_done_i   = 1'b0;
        step();
        chk("t2_stray_rv", {31'd0, report_valid_o}, 32'd0);
        poll_after_sof("t2_f2", 7'h15, 4'h5);
        do_ack("t2_f2");
        do_done("t2_nak2", R_NAK, 1'b0, 1'b0, 4'd0);
        poll_after_sof("t2_f3", 7'h15, 4'h5);
        do_ack("t2_f3");
        do_done("t2_ack", R_ACK, 1'b0, 1'b1, 4'd0);

        // Duplicate toggle=0 is dropped; expected toggle then 1
        restart_enable();
        poll_after_sof("t3_a", 7'h15, 4'h5);
        do_ack("t3_a");
        do_done("t3_first", R_ACK, 1'b0, 1'b1, 4'd0);
        poll_after_sof("t3_b", 7'h15, 4'h5);
        do_ack("t3_b");
        do_done("t3_dup", R_ACK, 1'b0, 1'b0, 4'd0);
        poll_after_sof("t3_c", 7'h15, 4'h5);
        do_ack("t3_c");
        do_done("t3_tog1", R_ACK, 1'b1, 1'b1, 4'd0);

        // Three errors halt; clear_halt resumes on the next frame
        for (int e = 1; e <= 3; e++) begin
            poll_after_sof("t4_err", 7'h15, 4'h5);
            do_ack("t4_err");
            do_done("t4_err", R_ERR, 1'b0, 1'b0, 4'(e));
        end
        chk("t4_halted", {31'd0, halted_o}, 32'd1);
        begin
            logic seen_req = 1'b0;
            for (int c = 0; c < 250; c++) begin
                step();
                if (xfer_req_o) seen_req = 1'b1;
            end
            chk("t4_halt_noreq", {31'd0, seen_req}, 32'd0);
        end
        chk("t4_still_halted", {31'd0, halted_o}, 32'd1);
        clear_halt_i = 1'b1;
        step();
        clear_halt_i = 1'b0;
        chk("t4_unhalt", {31'd0, halted_o}, 32'd0);
        chk("t4_err_clr", {28'd0, err_count_o}, 32'd0);
        poll_after_sof("t4_resume", 7'h15, 4'h5);
        do_ack("t4_resume");
        do_done("t4_resume", R_ACK, 1'b0, 1'b1, 4'd0);

        // Watchdog: no done after ack counts as an error after 1024 cycles
        poll_after_sof("t5", 7'h15, 4'h5);
        do_ack("t5");
        repeat (1023) step();
        chk("t5_err_before", {28'd0, err_count_o}, 32'd0);
        step();
        chk("t5_err_timeout", {28'd0, err_count_o}, 32'd1);
        chk("t5_not_halted", {31'd0, halted_o}, 32'd0);
        poll_after_sof("t5_retry", 7'h15, 4'h5);
        do_ack("t5_retry");
        do_done("t5_retry", R_ACK, 1'b1, 1'b1, 4'd0);

        // Disconnect in BUSY with expected toggle 1; reconnect must restart at 0
        poll_after_sof("t6_a", 7'h15, 4'h5);
        do_ack("t6_a");
        do_done("t6_a", R_ACK, 1'b0, 1'b1, 4'd0);
        poll_after_sof("t6_b", 7'h15, 4'h5);
        do_ack("t6_b");
        host_connect_i = 1'b0;
        #1;
        chk("t6_disc_req_now", {31'd0, xfer_req_o}, 32'd0);
        step();
        chk("t6_disc_req", {31'd0, xfer_req_o}, 32'd0);
        chk("t6_disc_rv", {31'd0, report_valid_o}, 32'd0);
        chk("t6_disc_halted", {31'd0, halted_o}, 32'd0);
        host_connect_i = 1'b1;
        step();
        poll_after_sof("t6_rc", 7'h15, 4'h5);
        do_ack("t6_rc");
        do_done("t6_rc", R_ACK, 1'b0, 1'b1, 4'd0);

        // Asynchronous reset while a request is pending
        poll_after_sof("t7", 7'h15, 4'h5);
        rst = 1'b1;
        #1;
        chk("t7_async_req", {31'd0, xfer_req_o}, 32'd0);
        chk("t7_async_addr", {25'd0, xfer_addr_o}, 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_poll_scheduler.md
Name: usb_poll_scheduler

Overview:
- Sequences periodic interrupt-IN polling of one device endpoint for the USB host.
- Generates the 1 ms frame tick.
- Issues transaction requests to the transaction FSM (new_fsm), then interprets each result (ACK/NAK/STALL/error).
- Tracks the DATA0/DATA1 toggle, applies retry and halt policy, and qualifies which received reports the capture path may publish.

Parameters:
- CLK_PER_MS, 60000, clk cycles per 1 ms frame (60 MHz ULPI clock); 100 in simulation.
- MAX_ERR, 3, consecutive errors before halt (1..15).
- TIMEOUT_CYC, 1024, watchdog cycles allowed for one transaction once accepted.

Ports:
- clk  in  1  ULPI clock
- rst  in  1  reset; asynchronous, active-high
- host_connect_i  in  1  device attached (from transaction FSM)
- enable_i  in  1  polling enable
- clear_halt_i  in  1  single-cycle pulse; leave HALT
- dev_addr_i  in  7  device address, sampled at REQ entry
- ep_i  in  4  endpoint number, sampled at REQ entry
- interval_i  in  8  poll interval in frames; 0 treated as 1
- xfer_req_o  out  1  transaction request, level
- xfer_ack_i  in  1  engine accepted request
- xfer_addr_o  out  7  registered address for request
- xfer_ep_o  out  4  registered endpoint for request
- xfer_done_i  in  1  single-cycle pulse; transaction finished
- xfer_result_i  in  2  0=DATA_ACK 1=NAK 2=STALL 3=ERR; valid with done
- rx_toggle_i  in  1  PID toggle of received data; valid with done
- sof_o  out  1  single-cycle frame tick
- report_valid_o  out  1  single-cycle pulse; accepted new report
- halted_o  out  1  in HALT
- err_count_o  out  4  consecutive error count

Behaviour:
- Reset: all outputs 0; state IDLE; expected toggle = 0; frame counter = 0; frames-remaining counter (fcnt) = 1.
- Frame timer:
  - Free-running counter 0..CLK_PER_MS-1, runs regardless of state.
  - sof_o is high on the cycle the counter equals CLK_PER_MS-1, so the tick period is exactly CLK_PER_MS cycles.
- States: IDLE, WAIT_FRAME, REQ, BUSY, HALT.
- IDLE:
  - Leave to WAIT_FRAME when host_connect_i && enable_i.
  - On that exit: fcnt=1, toggle=0, err_count_o=0.
- WAIT_FRAME:
  - On sof_o: if fcnt<=1 go to REQ; else fcnt decrements.
  - If enable_i is low, go to IDLE.
- REQ:
  - xfer_req_o=1 from the cycle after REQ entry; xfer_addr_o/xfer_ep_o hold the values sampled at entry.
  - On xfer_ack_i, go to BUSY; xfer_req_o drops the next cycle.
  - The request is never withdrawn for enable_i low; only a disconnect cancels it.
- BUSY:
  - The watchdog starts at 0 on entry.
  - xfer_done_i wins over a watchdog expiry in the same cycle.
  - DATA_ACK:
    - Clear err_count_o and load fcnt=max(interval_i,1).
    - If rx_toggle_i equals the expected toggle: flip the toggle and pulse report_valid_o the next cycle.
    - If it mismatches (duplicate): no flip, no pulse.
    - Next state: WAIT_FRAME.
  - NAK: fcnt=1, err count unchanged, go to WAIT_FRAME.
  - STALL: go to HALT.
  - ERR, or watchdog reaches TIMEOUT_CYC:
    - err_count_o saturates at 15.
    - If err_count_o reaches MAX_ERR, go to HALT; else fcnt=1 and go to WAIT_FRAME.
  - If enable_i is low at completion, go to IDLE instead of WAIT_FRAME (HALT still takes priority).
- HALT:
  - halted_o=1; no requests are issued.
  - clear_halt_i goes to WAIT_FRAME with err=0, toggle=0, fcnt=1.
- Disconnect:
  - host_connect_i low in any state means next state is IDLE.
  - xfer_req_o and report_valid_o are forced to 0 the same cycle; the toggle resets.
  - Disconnect has the highest priority over all other events.
- xfer_done_i outside BUSY is ignored.
- Mid-operation rst forces the reset values immediately (asynchronous).

Decomposition:
- usb_sched_pkg:
  - xfer_result_e enum (DATA_ACK, NAK, STALL, ERR).
  - sched_state_e enum.
  - Constant ERR_CNT_W=4.
- Sub-module usb_frame_timer (parameter CLK_PER_MS; ports clk, rst, sof_o).

Test Plan:
- CLK_PER_MS=100, interval_i=3, engine always returns DATA_ACK with alternating toggle:
  - xfer_req_o rises 1 cycle after every third sof_o.
  - report_valid_o pulses each poll.
  - Expected toggle alternates 0,1,0.
- Engine returns NAK twice, then DATA_ACK toggle=0 → requests on 3 consecutive frames; one report_valid_o; err_count_o stays 0.
- Duplicate data: two DATA_ACKs both toggle=0 → first pulses report_valid_o, second does not; expected toggle remains 1.
- ERR three times with MAX_ERR=3:
  - err_count_o goes 1,2,3, then halted_o=1 with no further requests.
  - clear_halt_i resumes polling on the next frame with err=0.
- No xfer_done_i after ack → timeout at 1024 cycles counts as ERR (err_count_o=1); retry on next frame.
- Drop host_connect_i while in BUSY → IDLE next cycle, xfer_req_o=0, toggle=0.
  - Reconnect → first request on the next sof_o.
